// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered, flow-controlled UART transmitter.
//   tx_state_e     : 2-bit FSM encoding (IDLE/START/DATA/STOP)
//   DEFAULT_CLK    : default system clock in Hz
//   DEFAULT_BPS    : default baud rate
//   DEFAULT_PERIOD : clock cycles per bit for the defaults (truncated)
//   FRAME_BITS     : bits per 8N1 frame (start + 8 data + stop)
//   CNT_W          : width of the per-bit down counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_CLK    = 7000000;
    localparam int DEFAULT_BPS    = 115200;
    localparam int DEFAULT_PERIOD = DEFAULT_CLK / DEFAULT_BPS;
    localparam int FRAME_BITS     = 10;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock show-ahead FIFO: rd_data always presents the head entry, so a
// consumer can take it in the same cycle it asserts rd_en.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en, wr_data    : enqueue strobe and data (ignored while full)
//   rd_en, rd_data    : dequeue strobe and head-of-queue data
//   full, empty       : occupancy flags
//   level             : occupancy count, 0..2**DEPTH_LOG2
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_wr;
    logic                  do_rd;

    // Flags come from the registered count, so a write in the same cycle as
    // a pop while full is still refused.
    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        // Occupancy is tracked in its own counter rather than derived from
        // the pointers, so full and empty never alias.
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; stale entries are never visible past the count.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cts.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_cts
// Buffered 8N1 UART transmitter (LSB first) gated by the peer's busy line.
// Bytes written by the CPU are queued and sent back-to-back while the peer is
// ready; a new frame only starts while the synchronised cts is low.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   wr_data    : byte to enqueue
//   wr_en      : enqueue strobe (one byte per cycle)
//   full/empty : FIFO occupancy flags
//   level      : FIFO occupancy count
//   overflow   : sticky flag, set by a write while full, cleared by reset
//   cts        : peer busy when high, asynchronous to clk
//   busy       : frame in progress or bytes still queued
//   tx         : registered serial output, idle high
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_tx_fifo_cts
    import uart_pkg::*;
#(
    parameter int CLK        = DEFAULT_CLK,
    parameter int BPS        = DEFAULT_BPS,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  cts,
    output logic                  busy,
    output logic                  tx
);

    localparam int PERIOD = CLK / BPS;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(PERIOD - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             cts_meta_q, cts_meta_d;
    logic             cts_s_q, cts_s_d;

    logic             fifo_rd_en;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             launch;

    uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_rd_en = 1'b0;
        cts_meta_d = cts;
        cts_s_d    = cts_meta_q;
        overflow_d = overflow_q || (wr_en && fifo_full);

        // A frame may begin only at a frame boundary with data waiting and
        // the peer seen ready; cts is never consulted mid-frame.
        launch = !fifo_empty && !cts_s_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    fifo_rd_en = 1'b1;
                    shift_d    = fifo_rd_data;
                    cnt_d      = BIT_RELOAD;
                    state_d    = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes go
                // out with no idle gap between frames.
                if (cnt_q == '0) begin
                    if (launch) begin
                        fifo_rd_en = 1'b1;
                        shift_d    = fifo_rd_data;
                        cnt_d      = BIT_RELOAD;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is a registered copy of the current state's bit, so
        // the pin trails the FSM by one cycle but is glitch-free.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // The synchroniser resets to "peer busy" so nothing leaves until the peer
    // has actually been observed ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_s_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            cts_meta_q <= cts_meta_d;
            cts_s_q    <= cts_s_d;
        end
    end

endmodule
